// File: rtl/mul_seq_if.sv
// Request, result and shared-adder signals of the shift-add multiplier sequencer.
// Latency: none, the interface only carries wires.
// Backpressure: busy low means a start is accepted; the adder returns its sum in the same cycle.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sgn;
  logic             cancel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  // Requester side: issues multiplies, consumes HI/LO, and owns the shared adder.
  modport master (
    output start, sgn, cancel, op_a, op_b, add_sum, add_cout,
    input  busy, done, hi, lo, add_a, add_b, add_cin
  );

  // Sequencer side.
  modport slave (
    input  start, sgn, cancel, op_a, op_b, add_sum, add_cout,
    output busy, done, hi, lo, add_a, add_b, add_cin
  );
endinterface

// File: rtl/mul_seq.sv
// Shift-add multiplier sequencer for MULT/MULTU, driving one external shared adder.
// Latency: WIDTH+1 cycles unsigned, WIDTH+5 cycles signed, start edge to done pulse.
// Backpressure: start is ignored while busy; cancel aborts in flight. Signed support: MUL_SIGNED_EN.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  mul_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL    = 3'd1
`ifdef MUL_SIGNED_EN
    ,
    NEG_A  = 3'd2,
    NEG_B  = 3'd3,
    FIX_LO = 3'd4,
    FIX_HI = 3'd5
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic [WIDTH-1:0]   add_a, add_b;
  logic               add_cin;
  logic               finish;
  logic               last_step;

`ifdef MUL_SIGNED_EN
  logic               is_sgn_q, is_sgn_d;
  logic               neg_res_q, neg_res_d;
  logic               fix_c_q, fix_c_d;
`else
  // The signed request flag has no meaning in an unsigned-only build.
  logic               unused_sgn;
  assign unused_sgn = bus.sgn;
`endif

  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // Next-state, adder operand selection and datapath next values.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    finish    = 1'b0;
`ifdef MUL_SIGNED_EN
    is_sgn_d  = is_sgn_q;
    neg_res_d = neg_res_q;
    fix_c_d   = fix_c_q;
`endif
    case (state_q)
      IDLE: begin
        // Cancel in the same cycle as start drops the request.
        if (bus.start && !bus.cancel) begin
          mcand_d   = bus.op_a;
          prod_d    = {{WIDTH{1'b0}}, bus.op_b};
          cnt_d     = '0;
`ifdef MUL_SIGNED_EN
          is_sgn_d  = bus.sgn;
          neg_res_d = 1'b0;
          fix_c_d   = 1'b0;
          state_d   = bus.sgn ? NEG_A : MUL;
`else
          state_d   = MUL;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      NEG_A: begin
        // Two's complement magnitude; 0x80..0 maps to itself and is read as unsigned.
        add_a     = mcand_q[WIDTH-1] ? ~mcand_q : mcand_q;
        add_cin   = mcand_q[WIDTH-1];
        mcand_d   = bus.add_sum;
        neg_res_d = mcand_q[WIDTH-1];
        state_d   = NEG_B;
      end
      NEG_B: begin
        add_a              = prod_q[WIDTH-1] ? ~prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        add_cin            = prod_q[WIDTH-1];
        prod_d[WIDTH-1:0]  = bus.add_sum;
        neg_res_d          = neg_res_q ^ prod_q[WIDTH-1];
        state_d            = MUL;
      end
`endif
      MUL: begin
        // Add the multiplicand into the high half when the current multiplier bit is set, then shift right.
        add_a   = prod_q[2*WIDTH-1:WIDTH];
        add_b   = prod_q[0] ? mcand_q : '0;
        prod_d  = {bus.add_cout, bus.add_sum, prod_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
`ifdef MUL_SIGNED_EN
          if (is_sgn_q) begin
            state_d = FIX_LO;
          end else begin
            finish  = 1'b1;
            state_d = IDLE;
          end
`else
          finish  = 1'b1;
          state_d = IDLE;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      FIX_LO: begin
        // Low half of the 2W-bit negate; its carry-out feeds the high half.
        add_a             = neg_res_q ? ~prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        add_cin           = neg_res_q;
        prod_d[WIDTH-1:0] = bus.add_sum;
        fix_c_d           = bus.add_cout;
        state_d           = FIX_HI;
      end
      FIX_HI: begin
        add_a                   = neg_res_q ? ~prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        add_cin                 = neg_res_q & fix_c_q;
        prod_d[2*WIDTH-1:WIDTH] = bus.add_sum;
        finish                  = 1'b1;
        state_d                 = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    // A flush abandons the operation: back to idle with no completion.
    if ((state_q != IDLE) && bus.cancel) begin
      state_d = IDLE;
      finish  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working registers: multiplicand, product, step counter and sign bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
`ifdef MUL_SIGNED_EN
      is_sgn_q  <= 1'b0;
      neg_res_q <= 1'b0;
      fix_c_q   <= 1'b0;
`endif
    end else begin
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
`ifdef MUL_SIGNED_EN
      is_sgn_q  <= is_sgn_d;
      neg_res_q <= neg_res_d;
      fix_c_q   <= fix_c_d;
`endif
    end
  end

  // Result registers only update on completion so intermediate products never show.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        hi_q <= prod_d[2*WIDTH-1:WIDTH];
        lo_q <= prod_d[WIDTH-1:0];
      end
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.add_a   = add_a;
  assign bus.add_b   = add_b;
  assign bus.add_cin = add_cin;

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle shift-add multiplier sequencer for the MIPS `MULT`/`MULTU` path. It computes the product with one shared 32-bit carry-lookahead adder (built from 4-bit CLA groups), which it drives over a fixed operand/result port pair. The sequencer owns the control FSM, the step counter, the product register and the HI/LO result registers. It sits beside the ALU in EX and hands HI/LO to the HI/LO register file on completion.

## Interface
- `WIDTH`, default 32: operand width. The product is 2×`WIDTH`.

- `CLK_I` input 1: clock, rising edge.
- `RST_I` input 1: synchronous, active-high reset.
- `START_I` input 1: request a multiply. Accepted only when `BUSY_O`=0.
- `SIGNED_I` input 1: 1 = `MULT`, 0 = `MULTU`. Sampled with `START_I`.
- `CANCEL_I` input 1: pipeline flush. Aborts any operation in flight.
- `OP_A_I` input WIDTH: multiplicand. Sampled with `START_I`.
- `OP_B_I` input WIDTH: multiplier. Sampled with `START_I`.
- `BUSY_O` output 1: operation in flight.
- `DONE_O` output 1: one-cycle completion pulse.
- `HI_O` output WIDTH: upper product word.
- `LO_O` output WIDTH: lower product word.
- `ADD_A_O` output WIDTH: adder operand A.
- `ADD_B_O` output WIDTH: adder operand B.
- `ADD_CIN_O` output 1: adder carry-in.
- `ADD_SUM_I` input WIDTH: adder sum. Combinational return in the same cycle.
- `ADD_COUT_I` input 1: adder carry-out.

## Operation
- Registers: `mcand`[W], product `P`[2W], step counter [$clog2(W)+1], `neg_res`, `fix_c`.
- FSM states: IDLE, NEG_A, NEG_B, MUL, FIX_LO, FIX_HI.
- **IDLE**:
  - `ADD_*` outputs are driven to 0.
  - On `START_I`, load `mcand`=`OP_A_I`, `P`={0,`OP_B_I`}, counter=0.
  - Then go to NEG_A if signed, else MUL.
- **NEG_A** (conditional magnitude of A):
  - If `mcand[W-1]`: A=~`mcand`, B=0, CIN=1. Otherwise A=`mcand`, B=0, CIN=0.
  - Write `mcand`=SUM.
  - Set `neg_res`=`OP_A` sign; go to NEG_B.
- **NEG_B**: same rule applied to `P[W-1:0]`. Set `neg_res` ^= B sign; go to MUL.
- **MUL** (W cycles):
  - A=`P[2W-1:W]`, B=`P[0]` ? `mcand` : 0, CIN=0.
  - `P` <= {COUT, SUM, `P[W-1:1]`}.
  - Counter increments. After step W, go to FIX_LO if signed, else finish.
- **FIX_LO**:
  - If `neg_res`: A=~`P[W-1:0]`, B=0, CIN=1. Otherwise pass through with CIN=0.
  - Write `P[W-1:0]`=SUM; latch `fix_c`=COUT.
- **FIX_HI**:
  - If `neg_res`: A=~`P[2W-1:W]`, B=0, CIN=`fix_c`. Otherwise pass through.
  - Write `P[2W-1:W]`; finish.
- **Finish**:
  - `HI_O`/`LO_O` <= final `P`, `DONE_O`<=1 for one cycle, FSM -> IDLE.
  - `HI_O`/`LO_O` hold until the next completion and never show intermediate values.
- **Width rules**:
  - The most negative operand, 0x8000_0000, has magnitude 2^31 and is handled as unsigned.
  - Zero result with `neg_res`=1 stays 0, because the carry ripples through FIX_HI.
- **Boundary conditions**:
  - `START_I` while `BUSY_O`=1: ignored.
  - `CANCEL_I` in any busy state: IDLE next cycle, no `DONE_O`, `HI_O`/`LO_O` unchanged.
  - `CANCEL_I` with `START_I` in IDLE: cancel wins, start dropped.
  - `RST_I` at any time, including mid-operation: IDLE next cycle.

## Timing
- Reset values: all outputs 0, FSM IDLE, all internal registers 0.
- Start accepted at edge k gives `BUSY_O`=1 from cycle k+1.
- Unsigned: MUL occupies cycles k+1..k+W. `DONE_O`=1 and results valid in cycle k+W+1, so latency is W+1 (33).
- Signed: NEG_A, NEG_B, W×MUL, FIX_LO, FIX_HI. `DONE_O` in cycle k+W+5, so latency is W+5 (37).
- `BUSY_O`=0 in the `DONE_O` cycle. A new `START_I` is accepted in that same cycle (back-to-back).
- Latency is fixed and independent of operand values.
- The adder path is combinational within one cycle; the block adds no adder-result register.

## Configuration
- `MUL_SIGNED_EN` defined:
  - NEG_A, NEG_B, FIX_LO, FIX_HI, `neg_res` and `fix_c` are present.
  - `SIGNED_I` is honoured as specified above.
- `MUL_SIGNED_EN` undefined:
  - Those four states and registers are compiled out.
  - `SIGNED_I` is ignored and every request runs unsigned with latency W+1.

## Test plan
- Unsigned 3 × 5: START at cycle 0 gives `DONE_O` at cycle 33 with HI=0x0000_0000, LO=0x0000_000F. `BUSY_O` is high in cycles 1–32.
- Unsigned 0xFFFF_FFFF × 0xFFFF_FFFF gives HI=0xFFFF_FFFE, LO=0x0000_0001.
- Signed, with `MUL_SIGNED_EN`:
  - 7 × −3 gives HI=0xFFFF_FFFF, LO=0xFFFF_FFEB at cycle 37.
  - 0x8000_0000 × 2 gives HI=0xFFFF_FFFF, LO=0x0000_0000.
  - −1 × 0 gives HI=0, LO=0.
- Cancel: with a prior result (HI=0, LO=0xF) held, start 9 × 9 and assert `CANCEL_I` in MUL step 10. Required: `BUSY_O`=0 next cycle, no `DONE_O`, HI/LO still 0/0xF.
- Busy handling:
  - `START_I` pulsed mid-operation is ignored; the first result is unaffected.
  - `START_I` in the `DONE_O` cycle launches the second multiply with no gap.
  - `RST_I` mid-MUL forces all outputs to 0 next cycle.
